// File: rtl/serial_adder_if.sv
// Start/busy/done handshake and operand/result bus for the serial adder.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: one BITS_PER_CYCLE-wide adder slice iterated
// STEPS times over WIDTH-bit operands, with a start/busy/done handshake.
module serial_adder #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus_io
);

    localparam int unsigned BPC     = BITS_PER_CYCLE;
    localparam int unsigned SLICE_W = BPC + 1;
    localparam int unsigned STEPS   = WIDTH / BPC;
    localparam int unsigned CNT_W   = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [SLICE_W-1:0] slice_d;
    logic               msb_cin_d;
    logic [WIDTH-1:0]   a_d;
    logic [WIDTH-1:0]   b_d;
    logic [WIDTH-1:0]   res_d;

    // Adder slice; carry lands in the top bit, result bits enter res from the MSB side
    always_comb begin
        slice_d   = SLICE_W'(a_q[BPC-1:0]) + SLICE_W'(b_q[BPC-1:0]) + SLICE_W'(carry_q);
        msb_cin_d = a_q[BPC-1] ^ b_q[BPC-1] ^ slice_d[BPC-1];
        a_d       = a_q >> BPC;
        b_d       = b_q >> BPC;
        res_d     = (res_q >> BPC) | (WIDTH'(slice_d[BPC-1:0]) << (WIDTH - BPC));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus_io.start) begin
                        a_q     <= bus_io.a;
                        b_q     <= bus_io.sub ? ~bus_io.b : bus_io.b;
                        carry_q <= bus_io.sub ? 1'b1 : bus_io.cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    res_q   <= res_d;
                    carry_q <= slice_d[BPC];
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        sum_q   <= res_d;
                        cout_q  <= slice_d[BPC];
                        ovf_q   <= msb_cin_d ^ slice_d[BPC];
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus_io.busy     = busy_q;
    assign bus_io.done     = done_q;
    assign bus_io.sum      = sum_q;
    assign bus_io.cout     = cout_q;
    assign bus_io.overflow = ovf_q;

endmodule
